// File: rtl/maxpool2x2_controller_if.sv
// rtl/maxpool2x2_controller_if.sv - handshake and BRAM port bundle for the 2x2 max-pool controller
//
// Purpose: groups the start/busy/done handshake, the conv BRAM read port and
// the pool BRAM write port of maxpool2x2_controller.
// Ports (signals):
//   start      controller input   run request, sampled only in IDLE
//   busy       controller output  run in progress
//   done       controller output  one-cycle completion pulse
//   ena_in     controller output  conv BRAM read enable
//   addra_in   controller output  conv BRAM read address
//   douta_in   controller input   conv BRAM read data, signed
//   ena_out    controller output  pool BRAM enable
//   wea_out    controller output  pool BRAM write enable
//   addra_out  controller output  pool BRAM write address
//   dina_out   controller output  pooled value
// Modports: master = controller side, slave = environment/BRAM side.
interface maxpool2x2_controller_if #(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDRESS_LENGTH_IN  = 10,
    parameter int ADDRESS_LENGTH_OUT = 8
);
    logic                          start;
    logic                          busy;
    logic                          done;
    logic                          ena_in;
    logic [ADDRESS_LENGTH_IN-1:0]  addra_in;
    logic [DATA_WIDTH-1:0]         douta_in;
    logic                          ena_out;
    logic                          wea_out;
    logic [ADDRESS_LENGTH_OUT-1:0] addra_out;
    logic [DATA_WIDTH-1:0]         dina_out;

    modport master (
        input  start, douta_in,
        output busy, done, ena_in, addra_in, ena_out, wea_out, addra_out, dina_out
    );

    modport slave (
        output start, douta_in,
        input  busy, done, ena_in, addra_in, ena_out, wea_out, addra_out, dina_out
    );
endinterface

// File: rtl/maxpool2x2_controller.sv
// rtl/maxpool2x2_controller.sv - signed 2x2 stride-2 max pool sequencer between conv and pool BRAMs
//
// Purpose: on a start pulse, reads one IN_WIDTH x IN_HEIGHT feature map from the
// conv BRAM (one read per cycle, windows in raster order), keeps a signed running
// max per 2x2 window and writes one pooled sample per window to the pool BRAM.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   maxpool2x2_controller_if.master (start/busy/done, conv read port, pool write port)
// Optional feature: define MAXPOOL_RELU_EN to clamp negative pooled values to 0.
module maxpool2x2_controller #(
    parameter int IN_WIDTH           = 24,
    parameter int IN_HEIGHT          = 24,
    parameter int DATA_WIDTH         = 16,
    parameter int ADDRESS_LENGTH_IN  = 10,
    parameter int ADDRESS_LENGTH_OUT = 8,
    parameter int RD_LATENCY         = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    maxpool2x2_controller_if.master bus
);
    localparam int OUT_W = IN_WIDTH / 2;
    localparam int OUT_H = IN_HEIGHT / 2;
    localparam int N     = OUT_W * OUT_H;
    localparam int AI    = ADDRESS_LENGTH_IN;
    localparam int AO    = ADDRESS_LENGTH_OUT;
    localparam int DW    = DATA_WIDTH;
    localparam int CW    = AO + 1;
    localparam int TL    = RD_LATENCY - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [AI-1:0]        r_ox;
    logic [AI-1:0]        r_oy;
    logic [1:0]           r_sub;            // {dy, dx} inside the current window

    logic                 r_tag_v [RD_LATENCY];
    logic                 r_tag_f [RD_LATENCY];
    logic                 r_tag_l [RD_LATENCY];

    logic signed [DW-1:0] r_max;
    logic                 r_wr_en;
    logic [AO-1:0]        r_wr_addr;
    logic [DW-1:0]        r_wr_data;
    logic [CW-1:0]        r_wr_cnt;         // one bit wider so N == 2^AO still compares

    logic                 w_reading;
    logic                 w_start_acc;
    logic                 w_last_col;
    logic                 w_last_read;
    logic                 w_issue_wr;
    logic                 w_final_wr;
    logic [AI-1:0]        w_rd_addr;
    logic signed [DW-1:0] w_din;
    logic signed [DW-1:0] w_max_next;
    logic signed [DW-1:0] w_pool_val;

    assign w_reading   = (r_state == S_READ);
    assign w_start_acc = (r_state == S_IDLE) && bus.start;
    assign w_last_col  = (r_ox == AI'(OUT_W - 1));
    assign w_last_read = w_reading && (r_sub == 2'd3) && w_last_col && (r_oy == AI'(OUT_H - 1));

    // (2*oy+dy)*IN_WIDTH + 2*ox + dx; trailing odd row/column never addressed
    assign w_rd_addr = (AI'(2) * r_oy + AI'(r_sub[1])) * AI'(IN_WIDTH)
                     + AI'(2) * r_ox + AI'(r_sub[0]);

    // The oldest tag lines up with the data currently on douta_in
    assign w_din      = bus.douta_in;
    assign w_max_next = (r_tag_f[TL] || (w_din > r_max)) ? w_din : r_max;
    assign w_issue_wr = r_tag_v[TL] && r_tag_l[TL];
    assign w_final_wr = r_wr_en && (r_wr_cnt == CW'(N));

`ifdef MAXPOOL_RELU_EN
    assign w_pool_val = w_max_next[DW-1] ? '0 : w_max_next;
`else
    assign w_pool_val = w_max_next;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)  w_state_next = S_READ;
            S_READ:  if (w_last_read) w_state_next = S_DRAIN;
            S_DRAIN: if (w_final_wr)  w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busy      = (r_state != S_IDLE);
        bus.done      = (r_state == S_FIN);
        bus.ena_in    = w_reading;
        bus.addra_in  = w_reading ? w_rd_addr : '0;
        bus.ena_out   = r_wr_en;
        bus.wea_out   = r_wr_en;
        bus.addra_out = r_wr_addr;
        bus.dina_out  = r_wr_data;
    end

    // Window / sub-window read counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ox  <= '0;
            r_oy  <= '0;
            r_sub <= '0;
        end else if (w_start_acc) begin
            r_ox  <= '0;
            r_oy  <= '0;
            r_sub <= '0;
        end else if (w_reading) begin
            r_sub <= r_sub + 2'd1;
            if (r_sub == 2'd3) begin
                if (w_last_col) begin
                    r_ox <= '0;
                    r_oy <= r_oy + AI'(1);
                end else begin
                    r_ox <= r_ox + AI'(1);
                end
            end
        end
    end

    // Read-issue tags travel alongside the BRAM latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_tag_v[i] <= 1'b0;
                r_tag_f[i] <= 1'b0;
                r_tag_l[i] <= 1'b0;
            end
        end else begin
            r_tag_v[0] <= w_reading;
            r_tag_f[0] <= w_reading && (r_sub == 2'd0);
            r_tag_l[0] <= w_reading && (r_sub == 2'd3);
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_f[i] <= r_tag_f[i-1];
                r_tag_l[i] <= r_tag_l[i-1];
            end
        end
    end

    // Running max and write port; address/data are zero outside write cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_max     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_cnt  <= '0;
        end else begin
            if (r_tag_v[TL]) begin
                r_max <= w_max_next;
            end
            r_wr_en   <= w_issue_wr;
            r_wr_addr <= w_issue_wr ? r_wr_cnt[AO-1:0] : '0;
            r_wr_data <= w_issue_wr ? w_pool_val : '0;
            if (w_start_acc) begin
                r_wr_cnt <= '0;
            end else if (w_issue_wr) begin
                r_wr_cnt <= r_wr_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_maxpool2x2_controller.sv
// tb/tb_maxpool2x2_controller.sv - self-checking bench for maxpool2x2_controller
module tb_maxpool2x2_controller;
    localparam int DW   = 16;
    localparam int AW   = 24;
    localparam int AH   = 24;
    localparam int ARD  = 1;
    localparam int AN   = (AW / 2) * (AH / 2);
    localparam int BW   = 5;
    localparam int BH   = 5;
    localparam int BRD  = 2;
    localparam int BN   = (BW / 2) * (BH / 2);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   t0a = 0;
    int   t0b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maxpool2x2_controller_if #(.DATA_WIDTH(DW), .ADDRESS_LENGTH_IN(10), .ADDRESS_LENGTH_OUT(8)) if_a ();
    maxpool2x2_controller_if #(.DATA_WIDTH(DW), .ADDRESS_LENGTH_IN(5),  .ADDRESS_LENGTH_OUT(2)) if_b ();

    maxpool2x2_controller #(
        .IN_WIDTH(AW), .IN_HEIGHT(AH), .DATA_WIDTH(DW),
        .ADDRESS_LENGTH_IN(10), .ADDRESS_LENGTH_OUT(8), .RD_LATENCY(ARD)
    ) u_dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_a.master)
    );

    maxpool2x2_controller #(
        .IN_WIDTH(BW), .IN_HEIGHT(BH), .DATA_WIDTH(DW),
        .ADDRESS_LENGTH_IN(5), .ADDRESS_LENGTH_OUT(2), .RD_LATENCY(BRD)
    ) u_dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_b.master)
    );

    // BRAM models: 1-cycle for A, 2-cycle for B
    logic [DW-1:0] mem_a [AW*AH];
    logic [DW-1:0] mem_b [BW*BH];
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b1;
    logic [DW-1:0] rd_b2;
    always @(posedge clk) begin
        if (if_a.ena_in) rd_a <= mem_a[int'(if_a.addra_in) % (AW*AH)];
        if (if_b.ena_in) rd_b1 <= mem_b[int'(if_b.addra_in) % (BW*BH)];
        rd_b2 <= rd_b1;
    end
    assign if_a.douta_in = rd_a;
    assign if_b.douta_in = rd_b2;

    // Monitors: cycle numbers are the edge at which the BRAM sees the strobe
    int wa_a[$], wd_a[$], wc_a[$], ra_a[$], rc_a[$], dc_a[$];
    int wa_b[$], wd_b[$], wc_b[$], ra_b[$], rc_b[$], dc_b[$];
    always @(negedge clk) begin
        if (if_a.ena_out && if_a.wea_out) begin
            wa_a.push_back(int'(if_a.addra_out));
            wd_a.push_back(int'($signed(if_a.dina_out)));
            wc_a.push_back(cyc + 1 - t0a);
        end
        if (if_a.ena_in) begin
            ra_a.push_back(int'(if_a.addra_in));
            rc_a.push_back(cyc + 1 - t0a);
        end
        if (if_a.done) dc_a.push_back(cyc + 1 - t0a);
        if (if_b.ena_out && if_b.wea_out) begin
            wa_b.push_back(int'(if_b.addra_out));
            wd_b.push_back(int'($signed(if_b.dina_out)));
            wc_b.push_back(cyc + 1 - t0b);
        end
        if (if_b.ena_in) begin
            ra_b.push_back(int'(if_b.addra_in));
            rc_b.push_back(cyc + 1 - t0b);
        end
        if (if_b.done) dc_b.push_back(cyc + 1 - t0b);
    end

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -999999;
    endfunction

    function automatic int act_a();
        return int'(|{if_a.busy, if_a.done, if_a.ena_in, if_a.addra_in, if_a.ena_out,
                      if_a.wea_out, if_a.addra_out, if_a.dina_out});
    endfunction

    function automatic int act_b();
        return int'(|{if_b.busy, if_b.done, if_b.ena_in, if_b.addra_in, if_b.ena_out,
                      if_b.wea_out, if_b.addra_out, if_b.dina_out});
    endfunction

    // mode 0 ramp, 1 -(addr+1), 2 full-range random, 3 small random (many ties)
    function automatic void fill_map(input int mode, input int n, output int m[$]);
        logic [15:0] r16;
        m = {};
        for (int i = 0; i < n; i++) begin
            r16 = 16'($urandom);
            case (mode)
                0:       m.push_back(i);
                1:       m.push_back(-(i + 1));
                2:       m.push_back(int'($signed(r16)));
                default: m.push_back(int'($urandom_range(0, 6)) - 3);
            endcase
        end
    endfunction

    // Reference: pooled values and expected read address order
    function automatic void build_exp(input int w, input int h, input int m[$],
                                      output int ed[$], output int er[$]);
        int best;
        int a;
        ed = {};
        er = {};
        for (int oy = 0; oy < h / 2; oy++) begin
            for (int ox = 0; ox < w / 2; ox++) begin
                best = m[(2 * oy) * w + 2 * ox];
                for (int dy = 0; dy < 2; dy++) begin
                    for (int dx = 0; dx < 2; dx++) begin
                        a = (2 * oy + dy) * w + 2 * ox + dx;
                        er.push_back(a);
                        if (m[a] > best) best = m[a];
                    end
                end
`ifdef MAXPOOL_RELU_EN
                if (best < 0) best = 0;
`endif
                ed.push_back(best);
            end
        end
    endfunction

    task automatic check_run(input string tag, input int n, input int rd,
                             input int ed[$], input int er[$],
                             input int wa[$], input int wd[$], input int wc[$],
                             input int ra[$], input int rc[$], input int dc[$]);
        int bad;
        check_val({tag, "/n_wr"}, wa.size(), n);
        for (int i = 0; i < n && i < wd.size(); i++)
            check_val($sformatf("%s/wr%0d_data", tag, i), wd[i], ed[i]);
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] != i || qget(wc, i) != 4 * (i + 1) + rd + 1) bad++;
        check_val({tag, "/wr_addr_cyc_bad"}, bad, 0);
        check_val({tag, "/last_wr_cyc"}, qget(wc, n - 1), 4 * n + rd + 1);
        check_val({tag, "/n_rd"}, ra.size(), er.size());
        bad = 0;
        for (int i = 0; i < ra.size(); i++)
            if (i >= er.size() || ra[i] != er[i] || qget(rc, i) != i + 1) bad++;
        check_val({tag, "/rd_addr_cyc_bad"}, bad, 0);
        check_val({tag, "/n_done"}, dc.size(), 1);
        check_val({tag, "/done_cyc"}, qget(dc, 0), 4 * n + rd + 2);
    endtask

    task automatic run_a(input string tag, input int mode, input int restart_at);
        int m[$];
        int ed[$];
        int er[$];
        fill_map(mode, AW * AH, m);
        foreach (m[i]) mem_a[i] = DW'(m[i]);
        build_exp(AW, AH, m, ed, er);
        wa_a = {}; wd_a = {}; wc_a = {}; ra_a = {}; rc_a = {}; dc_a = {};
        @(negedge clk);
        if_a.start = 1'b1;
        t0a = cyc + 1;
        @(negedge clk);
        if_a.start = 1'b0;
        check_val({tag, "/busy_run"}, int'(if_a.busy), 1);
        for (int k = 0; k < 4000 && dc_a.size() == 0; k++) begin
            @(negedge clk);
            if_a.start = (restart_at > 0 && cyc + 1 - t0a == restart_at);
        end
        if (dc_a.size() == 0) check_val({tag, "/done_timeout"}, 0, 1);
        @(negedge clk);
        if_a.start = 1'b0;
        repeat (12) @(negedge clk);
        check_val({tag, "/busy_idle"}, int'(if_a.busy), 0);
        check_run(tag, AN, ARD, ed, er, wa_a, wd_a, wc_a, ra_a, rc_a, dc_a);
    endtask

    task automatic run_b(input string tag, input int mode, input int fin_start);
        int m[$];
        int ed[$];
        int er[$];
        fill_map(mode, BW * BH, m);
        foreach (m[i]) mem_b[i] = DW'(m[i]);
        build_exp(BW, BH, m, ed, er);
        wa_b = {}; wd_b = {}; wc_b = {}; ra_b = {}; rc_b = {}; dc_b = {};
        @(negedge clk);
        if_b.start = 1'b1;
        t0b = cyc + 1;
        @(negedge clk);
        if_b.start = 1'b0;
        check_val({tag, "/busy_run"}, int'(if_b.busy), 1);
        for (int k = 0; k < 200 && dc_b.size() == 0; k++) begin
            @(negedge clk);
            // edge 4N+RD+2 samples start while the FSM sits in FIN
            if_b.start = (fin_start != 0 && cyc + 1 - t0b == 4 * BN + BRD + 2);
        end
        if (dc_b.size() == 0) check_val({tag, "/done_timeout"}, 0, 1);
        @(negedge clk);
        if_b.start = 1'b0;
        repeat (12) @(negedge clk);
        check_val({tag, "/busy_idle"}, int'(if_b.busy), 0);
        check_run(tag, BN, BRD, ed, er, wa_b, wd_b, wc_b, ra_b, rc_b, dc_b);
    endtask

    initial begin
        int bad;
        int neg0;
        int neg143;
`ifdef MAXPOOL_RELU_EN
        neg0   = 0;
        neg143 = 0;
`else
        neg0   = -1;
        neg143 = -551;
`endif
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outs_a", act_a(), 0);
        check_val("reset_outs_b", act_b(), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        run_a("ramp", 0, 0);
        check_val("ramp/out0", qget(wd_a, 0), 25);
        check_val("ramp/out1", qget(wd_a, 1), 27);
        check_val("ramp/out143", qget(wd_a, 143), 575);

        run_a("neg", 1, 0);
        check_val("neg/out0", qget(wd_a, 0), neg0);
        check_val("neg/out143", qget(wd_a, 143), neg143);

        run_a("restart100", 0, 100);
        run_a("rand_full", 2, 0);
        run_a("rand_ties", 3, 0);

        // Reset mid-run at cycle 50
        fill_map(0, AW * AH, ra_a);
        foreach (ra_a[i]) mem_a[i] = DW'(ra_a[i]);
        @(negedge clk);
        if_a.start = 1'b1;
        t0a = cyc + 1;
        @(negedge clk);
        if_a.start = 1'b0;
        for (int k = 0; k < 200 && (cyc + 1 - t0a) < 50; k++) @(negedge clk);
        check_val("midrst/busy_before", int'(if_a.busy), 1);
        rstn = 1'b0;
        #1;
        wa_a = {}; wd_a = {}; wc_a = {}; ra_a = {}; rc_a = {}; dc_a = {};
        check_val("midrst/outs_now", act_a(), 0);
        repeat (3) @(negedge clk);
        check_val("midrst/outs_held", act_a(), 0);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        check_val("midrst/no_wr", wa_a.size(), 0);
        check_val("midrst/no_rd", ra_a.size(), 0);
        check_val("midrst/no_done", dc_a.size(), 0);
        run_a("after_rst", 0, 0);
        check_val("after_rst/out0", qget(wd_a, 0), 25);
        check_val("after_rst/out143", qget(wd_a, 143), 575);

        run_b("b_ramp", 0, 0);
        check_val("b_ramp/out0", qget(wd_b, 0), 6);
        check_val("b_ramp/out1", qget(wd_b, 1), 8);
        check_val("b_ramp/out2", qget(wd_b, 2), 16);
        check_val("b_ramp/out3", qget(wd_b, 3), 18);
        bad = 0;
        foreach (ra_b[i])
            if (ra_b[i] == 4 || ra_b[i] == 9 || ra_b[i] == 14 || ra_b[i] >= 19) bad++;
        check_val("b_ramp/odd_edge_reads", bad, 0);
        check_val("b_ramp/done20", qget(dc_b, 0), 20);

        run_b("b_fin_start", 2, 1);
        run_b("b_rand", 3, 0);
        run_b("b_neg", 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/maxpool2x2_controller.md
Name: maxpool2x2_controller

Overview:
- Downstream stage of the conv layer memory controller.
- Reads the conv feature map from the conv output BRAM through port A, one map of IN_WIDTH x IN_HEIGHT.
- Computes a signed 2x2, stride-2 max pool and writes the pooled map into the pool output BRAM.
- Self-sequencing: a start pulse runs one full map; a done pulse reports completion.

Parameters:
- IN_WIDTH, 24, feature-map width in samples.
- IN_HEIGHT, 24, feature-map height in samples.
- DATA_WIDTH, 16, signed sample width.
- ADDRESS_LENGTH_IN, 10, conv BRAM address width; must satisfy 2^ADDRESS_LENGTH_IN >= IN_WIDTH*IN_HEIGHT.
- ADDRESS_LENGTH_OUT, 8, pool BRAM address width; must satisfy 2^ADDRESS_LENGTH_OUT >= OUT_W*OUT_H.
- RD_LATENCY, 1, conv BRAM read latency in cycles; legal range 1..3.
- Derived: OUT_W = floor(IN_WIDTH/2), OUT_H = floor(IN_HEIGHT/2), N = OUT_W*OUT_H.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final write.
- ena_in  output  1  conv BRAM read enable.
- addra_in  output  ADDRESS_LENGTH_IN  conv BRAM read address.
- douta_in  input  DATA_WIDTH  conv BRAM read data, signed.
- ena_out  output  1  pool BRAM enable.
- wea_out  output  1  pool BRAM write enable.
- addra_out  output  ADDRESS_LENGTH_OUT  pool BRAM write address.
- dina_out  output  DATA_WIDTH  pooled value.

Behaviour:
- Clock and reset:
  - Single clock clk; rstn is asynchronous, active-low.
  - While rstn is low, all outputs are 0, the FSM is in IDLE, and all counters, latency tags and the running max are cleared.
- FSM states: IDLE, READ, DRAIN, FIN.
  - IDLE: start=1 moves to READ at the next edge. busy=0.
  - READ: issues one read per cycle with ena_in=1. Windows run in raster order (oy outer, ox inner). Within a window the 4 reads go in order (0,0), (0,1), (1,0), (1,1).
  - READ read address: addra_in = (2*oy+dy)*IN_WIDTH + 2*ox + dx.
  - READ moves to DRAIN on the same edge that issues the 4N-th read.
  - DRAIN: ena_in=0. Moves to FIN once the final write has been issued.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Timing: let cycle 0 be the edge at which start is sampled.
  - Reads occur in cycles 1..4N, with no bubbles.
  - Data for a read issued in cycle k is sampled in cycle k+RD_LATENCY. Issue tracking uses a RD_LATENCY-deep shift register of {valid, last-of-window} tags.
- Max datapath:
  - A tag with the first-of-window flag loads the running max.
  - Each subsequent tag replaces it only if douta_in > max, by signed compare. Ties keep the existing value.
- Writes:
  - On the cycle after the 4th sample of a window is sampled: ena_out=1, wea_out=1, addra_out = oy*OUT_W + ox, dina_out = max.
  - All three strobes are low on every other cycle.
  - The final write occurs at cycle 4N+RD_LATENCY+1 and done occurs at 4N+RD_LATENCY+2.
  - Exactly N writes per run.
- Odd dimensions: the trailing odd column and row are never read.
- start while busy=1 is ignored and has no effect on the run in progress.
- Reset mid-operation aborts immediately. There is no partial write and no done pulse. The next start begins a fresh map from window 0.
- No arithmetic widening: dina_out is DATA_WIDTH bits and equals one of the four inputs, bit-exact.
- start in FIN is ignored; a new start is accepted once back in IDLE.

Optional Feature:
- Macro MAXPOOL_RELU_EN.
- When defined: dina_out = (max < 0) ? 0 : max, i.e. ReLU fused after pooling. Latency and all strobes are unchanged.
- When undefined: dina_out = max, signed, unmodified.

Test Plan:
- Ramp map, 24x24, RD_LATENCY=1, douta = address (1-cycle BRAM model) -> 144 writes; out[0]=25, out[1]=27, out[143]=575; last write at cycle 578, done at cycle 579.
- All-negative map with the value -(address+1) and the macro undefined -> each output equals the top-left sample; out[0]=-1, out[143]=-(22*24+22+1)=-551.
- Same stimulus with MAXPOOL_RELU_EN defined -> every dina_out=0, 144 writes, same cycle count.
- Second start pulsed at cycle 100 of a run -> ignored; still exactly 144 writes and a single done pulse at 579.
- rstn dropped at cycle 50 then released, followed by a new start -> all outputs 0 during reset, no write between reset and the new start; the new run reproduces the scenario-1 output.
- IN_WIDTH=5, IN_HEIGHT=5, RD_LATENCY=2, ramp data -> N=4; outputs 6, 8, 16, 18; addresses 4, 9, 14, 19-24 never read; done at cycle 20.
